// File: rtl/llist_fifo_ctrl_if.sv
// Producer/consumer and free-list handshake bundle
// for the linked-list FIFO controller.
interface llist_fifo_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int DWIDTH = 16
);
  logic              flist_init_done;
  logic              push_valid;
  logic [DWIDTH-1:0] push_data;
  logic              push_ready;
  logic              pop_req;
  logic              pop_ready;
  logic              pop_ack;
  logic [DWIDTH-1:0] pop_data;
  logic              pop_err;
  logic              empty;
  logic [WIDTH:0]    count;
  logic              alloc_req;
  logic              alloc_ack;
  logic [WIDTH-1:0]  alloc_id;
  logic              dealloc_req;
  logic [WIDTH-1:0]  dealloc_id;
  logic              dealloc_ack;

  modport slave (
    input  flist_init_done, push_valid, push_data,
    input  pop_req, alloc_ack, alloc_id, dealloc_ack,
    output push_ready, pop_ready, pop_ack, pop_data,
    output pop_err, empty, count,
    output alloc_req, dealloc_req, dealloc_id
  );

  modport master (
    output flist_init_done, push_valid, push_data,
    output pop_req, alloc_ack, alloc_id, dealloc_ack,
    input  push_ready, pop_ready, pop_ack, pop_data,
    input  pop_err, empty, count,
    input  alloc_req, dealloc_req, dealloc_id
  );
endinterface

// File: rtl/llist_fifo_ctrl.sv
// Linked-list FIFO whose slots are borrowed from
// an external free-list allocator.
module llist_fifo_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 256,
  parameter int DWIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  llist_fifo_ctrl_if.slave bus
);
  localparam logic [1:0] P_IDLE   = 2'd0;
  localparam logic [1:0] P_ALLOC  = 2'd1;
  localparam logic [1:0] P_WRITE  = 2'd2;
  localparam logic [1:0] Q_IDLE   = 2'd0;
  localparam logic [1:0] Q_READ   = 2'd1;
  localparam logic [1:0] Q_COMMIT = 2'd2;
  localparam logic [1:0] Q_WAIT   = 2'd3;

  logic [1:0]        r_pst;
  logic [1:0]        r_qst;
  logic [DWIDTH-1:0] r_pdata;
  logic [WIDTH-1:0]  r_pid;
  logic              r_alloc_req;
  logic [WIDTH-1:0]  r_head;
  logic [WIDTH-1:0]  r_tail;
  logic [WIDTH:0]    r_count;
  logic              r_pop_pend;
  logic              r_pop_ack;
  logic              r_pop_err;
  logic [DWIDTH-1:0] r_pop_data;
  logic              r_dealloc_req;
  logic [WIDTH-1:0]  r_dealloc_id;
  logic [DWIDTH-1:0] r_rd_data;
  logic [WIDTH-1:0]  r_rd_nxt;
  logic [DWIDTH-1:0] r_data_mem [DEPTH];
  logic [WIDTH-1:0]  r_nxt_mem  [DEPTH];

  logic w_empty;
  logic w_push_rdy;
  logic w_push_acc;
  logic w_wr_go;
  logic w_pop_in;
  logic w_pop_go;

  assign w_empty    = (r_count == '0);
  assign w_push_rdy = bus.flist_init_done && !rst &&
                      (r_pst == P_IDLE);
  assign w_push_acc = w_push_rdy && bus.push_valid;
  // List edits from push and pop never overlap.
  assign w_wr_go    = (r_pst == P_WRITE) &&
                      (r_qst != Q_READ) &&
                      (r_qst != Q_COMMIT);
  assign w_pop_in   = bus.flist_init_done && bus.pop_req &&
                      (r_qst == Q_IDLE);
  assign w_pop_go   = (r_qst == Q_IDLE) && !w_empty &&
                      (w_pop_in || r_pop_pend) &&
                      (r_pst != P_WRITE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pst       <= P_IDLE;
      r_pdata     <= '0;
      r_pid       <= '0;
      r_alloc_req <= 1'b0;
    end else begin
      r_alloc_req <= 1'b0;
      unique case (1'b1)
        (r_pst == P_IDLE): begin
          if (w_push_acc) begin
            r_pdata     <= bus.push_data;
            r_alloc_req <= 1'b1;
            r_pst       <= P_ALLOC;
          end
        end
        (r_pst == P_ALLOC): begin
          if (bus.alloc_ack) begin
            r_pid <= bus.alloc_id;
            r_pst <= P_WRITE;
          end
        end
        (r_pst == P_WRITE): begin
          if (w_wr_go) r_pst <= P_IDLE;
        end
        default: r_pst <= P_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_qst         <= Q_IDLE;
      r_pop_pend    <= 1'b0;
      r_pop_ack     <= 1'b0;
      r_pop_err     <= 1'b0;
      r_pop_data    <= '0;
      r_dealloc_req <= 1'b0;
      r_dealloc_id  <= '0;
    end else begin
      r_pop_ack     <= 1'b0;
      r_pop_err     <= 1'b0;
      r_dealloc_req <= 1'b0;
      unique case (1'b1)
        (r_qst == Q_IDLE): begin
          if (w_pop_go) begin
            r_pop_pend <= 1'b0;
            r_qst      <= Q_READ;
          end else if (w_pop_in && w_empty) begin
            r_pop_err <= 1'b1;
          end else if (w_pop_in) begin
            r_pop_pend <= 1'b1;
          end
        end
        (r_qst == Q_READ): r_qst <= Q_COMMIT;
        (r_qst == Q_COMMIT): begin
          r_pop_data    <= r_rd_data;
          r_pop_ack     <= 1'b1;
          r_dealloc_id  <= r_head;
          r_dealloc_req <= 1'b1;
          r_qst         <= Q_WAIT;
        end
        default: begin
          if (bus.dealloc_ack) r_qst <= Q_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_wr_go) begin
      if (w_empty) r_head <= r_pid;
      r_tail  <= r_pid;
      r_count <= r_count + 1'b1;
    end else if (r_qst == Q_COMMIT) begin
      if (r_count != (WIDTH+1)'(1)) r_head <= r_rd_nxt;
      r_count <= r_count - 1'b1;
    end
  end

  // Storage carries no reset; contents are gated by count.
  always_ff @(posedge clk) begin
    if (w_wr_go) begin
      r_data_mem[r_pid] <= r_pdata;
      if (!w_empty) r_nxt_mem[r_tail] <= r_pid;
    end
    if (r_qst == Q_READ) begin
      r_rd_data <= r_data_mem[r_head];
      r_rd_nxt  <= r_nxt_mem[r_head];
    end
  end

  assign bus.push_ready  = w_push_rdy;
  assign bus.pop_ready   = bus.flist_init_done && !rst &&
                           (r_qst == Q_IDLE) && !w_empty;
  assign bus.pop_ack     = r_pop_ack;
  assign bus.pop_data    = r_pop_data;
  assign bus.pop_err     = r_pop_err;
  assign bus.empty       = w_empty;
  assign bus.count       = r_count;
  assign bus.alloc_req   = r_alloc_req;
  assign bus.dealloc_req = r_dealloc_req;
  assign bus.dealloc_id  = r_dealloc_id;
endmodule

// File: tb/tb_llist_fifo_ctrl.sv
// Randomised bench for llist_fifo_ctrl with a
// behavioural free-list model and FIFO scoreboard.
module tb_llist_fifo_ctrl;
  localparam int WIDTH  = 8;
  localparam int DWIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  llist_fifo_ctrl_if #(.WIDTH(WIDTH), .DWIDTH(DWIDTH)) bus();

  llist_fifo_ctrl #(
    .WIDTH(WIDTH), .DEPTH(256), .DWIDTH(DWIDTH)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0]  pool[$];
  logic [WIDTH-1:0]  exp_ids[$];
  logic [DWIDTH-1:0] ref_q[$];
  logic [DWIDTH-1:0] pops[$];
  logic [WIDTH-1:0]  deallocs[$];
  int  n_areq = 0;
  int  n_perr = 0;
  bit  rand_dly = 1'b0;
  int  fix_dly = 0;

  // Free-list allocator: hands out ids from pool in order.
  initial begin : fl_alloc
    int d;
    bit ab;
    bus.alloc_ack = 1'b0;
    bus.alloc_id  = '0;
    forever begin
      @(negedge clk);
      bus.alloc_ack = 1'b0;
      if (bus.alloc_req === 1'b1 && !rst) begin
        d  = rand_dly ? int'($urandom_range(0, 7)) : fix_dly;
        ab = 1'b0;
        for (int k = 0; k < d; k++) begin
          @(negedge clk);
          if (rst) ab = 1'b1;
        end
        while (!ab && pool.size() == 0) begin
          @(negedge clk);
          if (rst) ab = 1'b1;
        end
        if (!ab) begin
          bus.alloc_ack = 1'b1;
          bus.alloc_id  = pool.pop_front();
          exp_ids.push_back(bus.alloc_id);
        end
      end
    end
  end

  initial begin : fl_dealloc
    int d;
    logic [WIDTH-1:0] id;
    bus.dealloc_ack = 1'b0;
    forever begin
      @(negedge clk);
      bus.dealloc_ack = 1'b0;
      if (bus.dealloc_req === 1'b1 && !rst) begin
        id = bus.dealloc_id;
        d  = rand_dly ? int'($urandom_range(0, 7)) : 0;
        for (int k = 0; k < d; k++) @(negedge clk);
        bus.dealloc_ack = 1'b1;
        pool.push_back(id);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pop_ack === 1'b1) pops.push_back(bus.pop_data);
      if (bus.dealloc_req === 1'b1)
        deallocs.push_back(bus.dealloc_id);
      if (bus.pop_err === 1'b1) n_perr++;
      if (bus.alloc_req === 1'b1) n_areq++;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_count(input int c, input string nm);
    int n;
    n = 0;
    while (bus.count !== 9'(c) && n < 150) begin
      tick();
      n++;
    end
    checks++;
    if (bus.count !== 9'(c)) begin
      errors++;
      $display("FAIL %s: count=%0d expected %0d", nm, bus.count, c);
    end
  endtask

  task automatic do_push(input logic [DWIDTH-1:0] d);
    int n;
    n = 0;
    while (bus.push_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (bus.push_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_ready_timeout: push_ready=%b expected 1",
               bus.push_ready);
      return;
    end
    bus.push_valid = 1'b1;
    bus.push_data  = d;
    @(negedge clk);
    bus.push_valid = 1'b0;
    ref_q.push_back(d);
  endtask

  task automatic issue_pop();
    int n;
    n = 0;
    while (bus.pop_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (bus.pop_ready !== 1'b1) begin
      errors++;
      $display("FAIL pop_ready_timeout: pop_ready=%b expected 1",
               bus.pop_ready);
      return;
    end
    bus.pop_req = 1'b1;
    @(negedge clk);
    bus.pop_req = 1'b0;
  endtask

  task automatic check_pop(input string nm);
    int n;
    logic [DWIDTH-1:0] ed;
    logic [WIDTH-1:0]  ei;
    n = 0;
    while (pops.size() == 0 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (pops.size() == 0 || ref_q.size() == 0) begin
      errors++;
      $display("FAIL %s_ack: pops=%0d ref=%0d expected a pop_ack",
               nm, pops.size(), ref_q.size());
      return;
    end
    ed = ref_q.pop_front();
    checks++;
    if (pops[0] !== ed) begin
      errors++;
      $display("FAIL %s_data: pop_data=%h expected %h",
               nm, pops[0], ed);
    end
    void'(pops.pop_front());
    checks++;
    if (deallocs.size() == 0 || exp_ids.size() == 0) begin
      errors++;
      $display("FAIL %s_dealloc: deallocs=%0d expected 1",
               nm, deallocs.size());
      return;
    end
    ei = exp_ids.pop_front();
    if (deallocs[0] !== ei) begin
      errors++;
      $display("FAIL %s_dealloc_id: dealloc_id=%h expected %h",
               nm, deallocs[0], ei);
    end
    void'(deallocs.pop_front());
  endtask

  task automatic do_pop(input string nm);
    issue_pop();
    check_pop(nm);
  endtask

  task automatic test_reset();
    int n;
    repeat (2) tick();
    checks++;
    if ({bus.empty, bus.count} !== {1'b1, 9'd0}) begin
      errors++;
      $display("FAIL reset_state: empty=%b count=%0d expected 1/0",
               bus.empty, bus.count);
    end
    rst = 1'b0;
    bus.push_valid = 1'b1;
    bus.push_data  = 16'h1234;
    bus.pop_req    = 1'b1;
    n = 0;
    repeat (10) begin
      tick();
      if (bus.push_ready !== 1'b0) n++;
    end
    bus.push_valid = 1'b0;
    bus.pop_req    = 1'b0;
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL noinit_ready: push_ready high %0d cycles expected 0",
               n);
    end
    checks++;
    if (n_areq != 0 || n_perr != 0) begin
      errors++;
      $display("FAIL noinit_traffic: alloc_req=%0d pop_err=%0d expected 0/0",
               n_areq, n_perr);
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.count !== 9'd0) begin
      errors++;
      $display("FAIL noinit_state: empty=%b count=%0d expected 1/0",
               bus.empty, bus.count);
    end
    bus.flist_init_done = 1'b1;
    pool.delete();
    do_push(16'hBEEF);
    n = 0;
    while (n_areq == 0 && n < 20) begin
      tick();
      n++;
    end
    repeat (3) tick();
    checks++;
    if (n_areq != 1 || bus.push_ready !== 1'b0) begin
      errors++;
      $display("FAIL alloc_wait: alloc_req=%0d push_ready=%b expected 1/0",
               n_areq, bus.push_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.push_ready, bus.pop_ready, bus.pop_ack, bus.pop_err,
         bus.alloc_req, bus.dealloc_req, bus.empty} !== 7'b0000001) begin
      errors++;
      $display("FAIL rst_flags: flags=%b expected 0000001",
               {bus.push_ready, bus.pop_ready, bus.pop_ack, bus.pop_err,
                bus.alloc_req, bus.dealloc_req, bus.empty});
    end
    checks++;
    if ({bus.count, bus.pop_data, bus.dealloc_id} !== '0) begin
      errors++;
      $display("FAIL rst_values: count=%0d pop_data=%h dealloc_id=%h expected 0",
               bus.count, bus.pop_data, bus.dealloc_id);
    end
    repeat (2) tick();
    rst = 1'b0;
    ref_q.delete();
    exp_ids.delete();
    pops.delete();
    deallocs.delete();
    n_areq = 0;
    tick();
    checks++;
    if (bus.push_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_ready: push_ready=%b expected 1",
               bus.push_ready);
    end
  endtask

  task automatic test_single();
    pool = '{8'h00};
    fix_dly = 2;
    do_push(16'hA5A5);
    wait_count(1, "single_count");
    issue_pop();
    tick();
    checks++;
    if (bus.pop_ack !== 1'b0) begin
      errors++;
      $display("FAIL pop_early: pop_ack=%b expected 0", bus.pop_ack);
    end
    tick();
    checks++;
    if (bus.pop_ack !== 1'b1 || bus.pop_data !== 16'hA5A5) begin
      errors++;
      $display("FAIL pop_latency: pop_ack=%b data=%h expected 1/a5a5",
               bus.pop_ack, bus.pop_data);
    end
    checks++;
    if (bus.dealloc_req !== 1'b1 || bus.dealloc_id !== 8'h00) begin
      errors++;
      $display("FAIL single_dealloc: req=%b id=%h expected 1/00",
               bus.dealloc_req, bus.dealloc_id);
    end
    checks++;
    if (bus.count !== 9'd0 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL single_empty: count=%0d empty=%b expected 0/1",
               bus.count, bus.empty);
    end
    repeat (4) tick();
    void'(ref_q.pop_front());
    void'(exp_ids.pop_front());
    pops.delete();
    deallocs.delete();
  endtask

  task automatic test_order();
    pool = '{8'h05, 8'h09, 8'h02};
    fix_dly = 0;
    do_push(16'h0001);
    do_push(16'h0002);
    do_push(16'h0003);
    wait_count(3, "order_fill");
    for (int i = 0; i < 3; i++) do_pop("order");
    wait_count(0, "order_drain");
  endtask

  task automatic test_pop_empty();
    int e0;
    int d0;
    repeat (4) tick();
    e0 = n_perr;
    d0 = deallocs.size();
    bus.pop_req = 1'b1;
    @(negedge clk);
    bus.pop_req = 1'b0;
    #1;
    checks++;
    if (bus.pop_err !== 1'b1) begin
      errors++;
      $display("FAIL pop_err: pop_err=%b expected 1", bus.pop_err);
    end
    tick();
    checks++;
    if (bus.pop_err !== 1'b0) begin
      errors++;
      $display("FAIL pop_err_pulse: pop_err=%b expected 0", bus.pop_err);
    end
    repeat (4) tick();
    checks++;
    if (n_perr - e0 != 1 || deallocs.size() != d0 ||
        bus.count !== 9'd0) begin
      errors++;
      $display("FAIL pop_empty_side: errs=%0d deallocs=%0d count=%0d expected 1/%0d/0",
               n_perr - e0, deallocs.size(), bus.count, d0);
    end
  endtask

  task automatic test_collision();
    int n;
    pool = '{8'h30, 8'h31};
    fix_dly = 0;
    do_push(16'h1111);
    wait_count(1, "coll_fill");
    fix_dly = 3;
    do_push(16'h2222);
    n = 0;
    while (bus.alloc_ack !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.alloc_ack !== 1'b1) begin
      errors++;
      $display("FAIL coll_ack: alloc_ack=%b expected 1", bus.alloc_ack);
    end
    bus.pop_req = 1'b1;
    @(negedge clk);
    bus.pop_req = 1'b0;
    check_pop("coll_first");
    wait_count(1, "coll_count");
    do_pop("coll_second");
    wait_count(0, "coll_drain");
  endtask

  task automatic test_random();
    int pushes;
    int e0;
    pool = '{8'h40, 8'h41, 8'h42, 8'h43};
    rand_dly = 1'b1;
    e0 = n_perr;
    n_areq = 0;
    pushes = 0;
    for (int i = 0; i < 5; i++) begin
      do_push(16'($urandom));
      pushes++;
    end
    wait_count(4, "exhaust_count");
    repeat (30) tick();
    checks++;
    if (bus.count !== 9'd4 || bus.push_ready !== 1'b0) begin
      errors++;
      $display("FAIL exhaust_stall: count=%0d push_ready=%b expected 4/0",
               bus.count, bus.push_ready);
    end
    do_pop("exhaust_pop");
    wait_count(4, "exhaust_refill");
    for (int i = 0; i < 1000; i++) begin
      if (ref_q.size() == 0 ||
          (ref_q.size() < 4 && $urandom_range(0, 1) == 1)) begin
        do_push(16'($urandom));
        pushes++;
      end else begin
        do_pop("rand");
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    while (ref_q.size() > 0) do_pop("drain");
    wait_count(0, "rand_drain");
    checks++;
    if (n_areq != pushes || n_perr != e0) begin
      errors++;
      $display("FAIL rand_counts: alloc_req=%0d pop_err=%0d expected %0d/%0d",
               n_areq, n_perr, pushes, e0);
    end
  endtask

  initial begin
    bus.flist_init_done = 1'b0;
    bus.push_valid      = 1'b0;
    bus.push_data       = '0;
    bus.pop_req         = 1'b0;
    test_reset();
    test_single();
    test_order();
    test_pop_empty();
    test_collision();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
